setare_multi: RTL and testbench
===============================

SETARE_MULTI -- requirements
Module: setare_multi

Interface
REQ-001 Parameter NUM_ALARME, default 4, number of alarm slots (1..8).
REQ-002 Parameter REP_DELAY, default 50_000_000, cycles a button is held before auto-repeat starts.
REQ-003 Parameter REP_RATE, default 10_000_000, cycles between auto-repeat increments.
REQ-004 Port clock, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port semnal_setare, input, 1, request to edit the time.
REQ-007 Port semnal_setare_a, input, 1, request to edit an alarm.
REQ-008 Port sel_alarma, input, $clog2(NUM_ALARME) (min 1), alarm slot to edit.
REQ-009 Port semnal_b1, input, 1, hour-increment button.
REQ-010 Port semnal_b2, input, 1, minute-increment button.
REQ-011 Port semnal_stop, input, 1, commit the edited value.
REQ-012 Port semnal_anulare, input, 1, abort the edit without loading.
REQ-013 Port ore_curent, input, 5, live hours, 0..23.
REQ-014 Port minute_curent, input, 6, live minutes, 0..59.
REQ-015 Port ore, output, 5, hours being edited.
REQ-016 Port minute, output, 6, minutes being edited.
REQ-017 Port load_timp, output, 1, one-cycle commit strobe for the time.
REQ-018 Port load_alarma, output, 1, one-cycle commit strobe for an alarm.
REQ-019 Port idx_alarma, output, $clog2(NUM_ALARME) (min 1), slot index qualified by load_alarma.
REQ-020 Port in_setare, output, 1, high while an edit is in progress.

Function
REQ-021 All inputs SHALL be treated as synchronous to clock; button inputs are level signals and edges are detected internally.
REQ-022 The FSM SHALL have the states IDLE, SET_TIMP, SET_ALARMA and COMMIT.
REQ-023 In IDLE, a rising edge on semnal_setare SHALL move to SET_TIMP and load ore/minute from ore_curent/minute_curent.
REQ-024 In IDLE, a rising edge on semnal_setare_a SHALL move to SET_ALARMA, latch sel_alarma into idx_alarma and load ore/minute from that slot's stored copy.
REQ-025 If both edges occur in IDLE in the same cycle, SET_TIMP SHALL win.
REQ-026 The block SHALL hold NUM_ALARME internal copies of {ore, minute}, each reset to 00:00 and updated on its commit.
REQ-027 In SET_* states, a rising edge on semnal_b1 SHALL increment ore the next cycle, wrapping 23->0.
REQ-028 In SET_* states, a rising edge on semnal_b2 SHALL increment minute the next cycle, wrapping 59->0 with no carry into ore.
REQ-029 Simultaneous b1 and b2 edges SHALL increment both fields in the same cycle.
REQ-030 A button held continuously SHALL produce its first repeat REP_DELAY cycles after the edge, then one repeat every REP_RATE cycles; each button has an independent counter, cleared on release.
REQ-031 semnal_stop high in a SET_* state SHALL move to COMMIT; COMMIT SHALL pulse load_timp or load_alarma for exactly one cycle, store the alarm copy if applicable, then return to IDLE.
REQ-032 If semnal_stop and a button increment occur in the same cycle, the increment SHALL be applied first, and the committed value SHALL include it.
REQ-033 semnal_anulare in a SET_* state SHALL return to IDLE with no strobe; it has priority over semnal_stop.
REQ-034 In IDLE, ore/minute SHALL follow ore_curent/minute_curent; in_setare SHALL be high in SET_* and COMMIT.
REQ-035 semnal_setare, semnal_setare_a, b1 and b2 edges occurring in IDLE or COMMIT, other than those starting an edit, SHALL be ignored.

Reset
REQ-036 Asserting reset (low) SHALL immediately force IDLE, ore=0, minute=0, load_timp=0, load_alarma=0, idx_alarma=0, in_setare=0, and clear all alarm copies, edge registers and repeat counters, including mid-edit.

Structure
REQ-037 A shared package setare_pkg SHALL hold the FSM state enum, MAX_ORE=23, MAX_MINUTE=59 and the widths 5 and 6.
REQ-038 Edge detection and auto-repeat SHALL be a single sub-module buton_repetare, instantiated twice (b1, b2).

Verification
REQ-039 Reset low mid-SET_TIMP -> next cycle: IDLE, all outputs 0, no strobe.
REQ-040 ore_curent=23, setare edge, one b1 edge, stop -> ore=0, minute unchanged, load_timp pulse of 1 cycle.
REQ-041 minute=59, b2 edge -> minute=0, ore unchanged.
REQ-042 setare_a with sel_alarma=2, b1 held 0 -> first repeat at REP_DELAY, next at +REP_RATE (test REP_DELAY=8, REP_RATE=3); stop -> load_alarma with idx_alarma=2; re-entering slot 2 shows the stored value.
REQ-043 Simultaneous setare and setare_a edges -> SET_TIMP; stop and anulare in the same cycle -> IDLE, no strobe.
REQ-044 b1, b2 and stop in the same cycle from 10:20 -> commit of 11:21.

Source files
------------

// File: rtl/setare_pkg.sv
// Shared types and constants for the time/alarm setting block.
// Holds the FSM state encoding, the {ore, minute} payload struct,
// field widths, wrap limits and the wrapping increment helpers.
package setare_pkg;

  localparam int unsigned W_ORE    = 5;
  localparam int unsigned W_MINUTE = 6;

  localparam logic [W_ORE-1:0]    MAX_ORE    = 5'd23;
  localparam logic [W_MINUTE-1:0] MAX_MINUTE = 6'd59;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SET_TIMP   = 2'd1,
    SET_ALARMA = 2'd2,
    COMMIT     = 2'd3
  } stare_t;

  typedef struct packed {
    logic [W_ORE-1:0]    ore;
    logic [W_MINUTE-1:0] minute;
  } timp_t;

  // Hour increment, 23 wraps to 0.
  function automatic logic [W_ORE-1:0] inc_ore(input logic [W_ORE-1:0] v);
    return (v == MAX_ORE) ? '0 : v + 5'd1;
  endfunction

  // Minute increment, 59 wraps to 0; never carries into the hour.
  function automatic logic [W_MINUTE-1:0] inc_minute(input logic [W_MINUTE-1:0] v);
    return (v == MAX_MINUTE) ? '0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/buton_repetare.sv
// Button edge detector with auto-repeat.
// Ports:
//   clock, reset  - rising-edge clock, async active-low reset
//   buton         - level button input, synchronous to clock
//   pas_c         - combinational one-cycle step: on the rising edge, then
//                   REP_DELAY cycles later, then every REP_RATE cycles while held
module buton_repetare #(
  parameter int unsigned REP_DELAY = 50_000_000,
  parameter int unsigned REP_RATE  = 10_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic buton,
  output logic pas_c
);

  localparam int unsigned MAXC = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  logic          prev;
  logic          repeta;
  logic [CW-1:0] cnt;
  logic          front_c;
  logic          tick_c;

  // cnt holds the number of cycles since the last step while held.
  assign front_c = buton & ~prev;
  assign tick_c  = buton & prev &
                   (repeta ? (cnt == CW'(REP_RATE)) : (cnt == CW'(REP_DELAY)));
  assign pas_c   = front_c | tick_c;

  // Edge register and repeat counter; release clears the counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev   <= 1'b0;
      repeta <= 1'b0;
      cnt    <= '0;
    end else begin
      prev <= buton;
      if (!buton) begin
        cnt    <= '0;
        repeta <= 1'b0;
      end else if (front_c) begin
        cnt    <= CW'(1);
        repeta <= 1'b0;
      end else if (tick_c) begin
        cnt    <= CW'(1);
        repeta <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/setare_multi.sv
// Time and multi-slot alarm editor.
// Ports:
//   clock, reset                  - rising-edge clock, async active-low reset
//   semnal_setare / semnal_setare_a - start editing the time / an alarm slot
//   sel_alarma                    - alarm slot chosen when an alarm edit starts
//   semnal_b1 / semnal_b2         - hour / minute increment buttons (auto-repeat)
//   semnal_stop / semnal_anulare  - commit / abort the edit
//   ore_curent, minute_curent     - live time, shown while idle
//   ore, minute                   - value being edited (registered)
//   load_timp / load_alarma       - one-cycle commit strobes
//   idx_alarma                    - slot qualified by load_alarma
//   in_setare                     - edit in progress
module setare_multi
  import setare_pkg::*;
#(
  parameter int unsigned NUM_ALARME = 4,
  parameter int unsigned REP_DELAY  = 50_000_000,
  parameter int unsigned REP_RATE   = 10_000_000,
  localparam int unsigned SW = (NUM_ALARME > 1) ? $clog2(NUM_ALARME) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                semnal_setare,
  input  logic                semnal_setare_a,
  input  logic [SW-1:0]       sel_alarma,
  input  logic                semnal_b1,
  input  logic                semnal_b2,
  input  logic                semnal_stop,
  input  logic                semnal_anulare,
  input  logic [W_ORE-1:0]    ore_curent,
  input  logic [W_MINUTE-1:0] minute_curent,
  output logic [W_ORE-1:0]    ore,
  output logic [W_MINUTE-1:0] minute,
  output logic                load_timp,
  output logic                load_alarma,
  output logic [SW-1:0]       idx_alarma,
  output logic                in_setare
);

  stare_t              stare, stare_nxt;
  logic                mod_alarma, mod_nxt;
  logic [W_ORE-1:0]    ore_nxt;
  logic [W_MINUTE-1:0] minute_nxt;
  logic [SW-1:0]       idx_nxt;
  logic [SW-1:0]       sel_c;
  logic                scrie_c;
  logic                prev_setare, prev_setare_a;
  logic                front_setare_c, front_setare_a_c;
  logic                pas_b1_c, pas_b2_c;
  timp_t               alarme [NUM_ALARME];

  assign front_setare_c   = semnal_setare & ~prev_setare;
  assign front_setare_a_c = semnal_setare_a & ~prev_setare_a;

  // Out-of-range slot selections map to the last slot.
  assign sel_c = (32'(sel_alarma) >= NUM_ALARME) ? SW'(NUM_ALARME - 1) : sel_alarma;

  buton_repetare #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_b1 (
    .clock (clock),
    .reset (reset),
    .buton (semnal_b1),
    .pas_c (pas_b1_c)
  );

  buton_repetare #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_b2 (
    .clock (clock),
    .reset (reset),
    .buton (semnal_b2),
    .pas_c (pas_b2_c)
  );

  // Next-state and next-value logic.
  always_comb begin
    stare_nxt  = stare;
    mod_nxt    = mod_alarma;
    ore_nxt    = ore;
    minute_nxt = minute;
    idx_nxt    = idx_alarma;
    scrie_c    = 1'b0;
    case (stare)
      IDLE: begin
        ore_nxt    = ore_curent;
        minute_nxt = minute_curent;
        if (front_setare_c) begin
          stare_nxt = SET_TIMP;
          mod_nxt   = 1'b0;
        end else if (front_setare_a_c) begin
          stare_nxt  = SET_ALARMA;
          mod_nxt    = 1'b1;
          idx_nxt    = sel_c;
          ore_nxt    = alarme[sel_c].ore;
          minute_nxt = alarme[sel_c].minute;
        end
      end
      SET_TIMP, SET_ALARMA: begin
        // Increments land before a same-cycle stop so the commit includes them.
        if (pas_b1_c) ore_nxt = inc_ore(ore);
        if (pas_b2_c) minute_nxt = inc_minute(minute);
        if (semnal_anulare) begin
          stare_nxt  = IDLE;
          ore_nxt    = ore_curent;
          minute_nxt = minute_curent;
        end else if (semnal_stop) begin
          stare_nxt = COMMIT;
        end
      end
      COMMIT: begin
        stare_nxt  = IDLE;
        scrie_c    = mod_alarma;
        ore_nxt    = ore_curent;
        minute_nxt = minute_curent;
      end
      default: stare_nxt = IDLE;
    endcase
  end

  // State, edit registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stare         <= IDLE;
      mod_alarma    <= 1'b0;
      ore           <= '0;
      minute        <= '0;
      idx_alarma    <= '0;
      load_timp     <= 1'b0;
      load_alarma   <= 1'b0;
      in_setare     <= 1'b0;
      prev_setare   <= 1'b0;
      prev_setare_a <= 1'b0;
    end else begin
      stare         <= stare_nxt;
      mod_alarma    <= mod_nxt;
      ore           <= ore_nxt;
      minute        <= minute_nxt;
      idx_alarma    <= idx_nxt;
      load_timp     <= (stare_nxt == COMMIT) & ~mod_nxt;
      load_alarma   <= (stare_nxt == COMMIT) & mod_nxt;
      in_setare     <= (stare_nxt != IDLE);
      prev_setare   <= semnal_setare;
      prev_setare_a <= semnal_setare_a;
    end
  end

  // Alarm copies, written while the commit strobe is up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARME; i++) alarme[i] <= '0;
    end else if (scrie_c) begin
      alarme[idx_alarma] <= timp_t'({ore, minute});
    end
  end

endmodule

// File: tb/tb_setare_multi.sv
// Bench for setare_multi: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a behavioural model.
module tb_setare_multi;

  localparam int NA = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       semnal_setare = 1'b0, semnal_setare_a = 1'b0;
  logic [1:0] sel_alarma = 2'd0;
  logic       semnal_b1 = 1'b0, semnal_b2 = 1'b0;
  logic       semnal_stop = 1'b0, semnal_anulare = 1'b0;
  logic [4:0] ore_curent = 5'd0;
  logic [5:0] minute_curent = 6'd0;
  logic [4:0] ore;
  logic [5:0] minute;
  logic       load_timp, load_alarma, in_setare;
  logic [1:0] idx_alarma;

  always #5 clock = ~clock;

  setare_multi #(.NUM_ALARME(NA), .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .clock           (clock),
    .reset           (reset),
    .semnal_setare   (semnal_setare),
    .semnal_setare_a (semnal_setare_a),
    .sel_alarma      (sel_alarma),
    .semnal_b1       (semnal_b1),
    .semnal_b2       (semnal_b2),
    .semnal_stop     (semnal_stop),
    .semnal_anulare  (semnal_anulare),
    .ore_curent      (ore_curent),
    .minute_curent   (minute_curent),
    .ore             (ore),
    .minute          (minute),
    .load_timp       (load_timp),
    .load_alarma     (load_alarma),
    .idx_alarma      (idx_alarma),
    .in_setare       (in_setare)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 editing time, 2 editing alarm, 3 committing
  int m_mode, m_ore, m_min, m_lt, m_la, m_idx, m_in, m_modal;
  int al_ore [NA];
  int al_min [NA];
  bit p_s, p_a, p_b1, p_b2;
  int h1, h2;   // cycles since the button's rising edge

  task automatic model_reset();
    m_mode = 0; m_ore = 0; m_min = 0; m_lt = 0; m_la = 0;
    m_idx = 0; m_in = 0; m_modal = 0;
    for (int i = 0; i < NA; i++) begin al_ore[i] = 0; al_min[i] = 0; end
    p_s = 0; p_a = 0; p_b1 = 0; p_b2 = 0; h1 = 0; h2 = 0;
  endtask

  // A step fires on the press and at hold lengths RD, RD+RR, RD+2RR, ...
  task automatic btn(input bit now, input bit prev, input int h_in,
                     output int h_out, output bit f);
    if (!now) begin
      h_out = h_in;
      f     = 1'b0;
    end else begin
      h_out = prev ? h_in + 1 : 0;
      f     = (h_out == 0) || (h_out >= RD && ((h_out - RD) % RR) == 0);
    end
  endtask

  task automatic model_step();
    bit es, ea, f1, f2;
    int n1, n2;
    es = semnal_setare && !p_s;
    ea = semnal_setare_a && !p_a;
    btn(semnal_b1, p_b1, h1, n1, f1);
    btn(semnal_b2, p_b2, h2, n2, f2);
    h1 = n1; h2 = n2;
    p_s = semnal_setare; p_a = semnal_setare_a;
    p_b1 = semnal_b1; p_b2 = semnal_b2;
    m_lt = 0; m_la = 0;
    case (m_mode)
      0: begin
        if (es) begin
          m_mode = 1; m_modal = 0;
          m_ore = int'(ore_curent); m_min = int'(minute_curent);
        end else if (ea) begin
          m_mode = 2; m_modal = 1; m_idx = int'(sel_alarma);
          m_ore = al_ore[m_idx]; m_min = al_min[m_idx];
        end else begin
          m_ore = int'(ore_curent); m_min = int'(minute_curent);
        end
      end
      1, 2: begin
        if (f1) m_ore = (m_ore + 1) % 24;
        if (f2) m_min = (m_min + 1) % 60;
        if (semnal_anulare) begin
          m_mode = 0;
          m_ore = int'(ore_curent); m_min = int'(minute_curent);
        end else if (semnal_stop) begin
          if (m_mode == 1) m_lt = 1; else m_la = 1;
          m_mode = 3;
        end
      end
      default: begin
        if (m_modal != 0) begin al_ore[m_idx] = m_ore; al_min[m_idx] = m_min; end
        m_mode = 0;
        m_ore = int'(ore_curent); m_min = int'(minute_curent);
      end
    endcase
    m_in = (m_mode != 0) ? 1 : 0;
  endtask

  // Compare on every falling edge, then advance the model with the inputs
  // that the next rising edge will sample.
  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      if (!reset) model_reset();
      chk("m_ore", int'(ore), m_ore);
      chk("m_minute", int'(minute), m_min);
      chk("m_load_timp", int'(load_timp), m_lt);
      chk("m_load_alarma", int'(load_alarma), m_la);
      chk("m_idx_alarma", int'(idx_alarma), m_idx);
      chk("m_in_setare", int'(in_setare), m_in);
      if (reset) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic quiet();
    semnal_setare = 0; semnal_setare_a = 0; semnal_b1 = 0; semnal_b2 = 0;
    semnal_stop = 0; semnal_anulare = 0;
  endtask

  bit hb1, hb2;

  initial begin
    // reset state
    reset = 0;
    tick(3);
    chk("rst_ore", int'(ore), 0);
    chk("rst_in_setare", int'(in_setare), 0);
    reset = 1;
    tick(1);

    // hour wrap 23 -> 0 and time commit
    ore_curent = 5'd23; minute_curent = 6'd17;
    tick(2);
    chk("idle_follow_ore", int'(ore), 23);
    semnal_setare = 1; tick(1);
    chk("set_timp_in", int'(in_setare), 1);
    chk("set_timp_load_min", int'(minute), 17);
    semnal_setare = 0; semnal_b1 = 1; tick(1);
    chk("wrap_ore", int'(ore), 0);
    chk("wrap_ore_min", int'(minute), 17);
    semnal_b1 = 0; semnal_stop = 1; tick(1);
    chk("commit_load_timp", int'(load_timp), 1);
    chk("commit_ore", int'(ore), 0);
    semnal_stop = 0; tick(1);
    chk("load_timp_one_cycle", int'(load_timp), 0);
    chk("back_idle", int'(in_setare), 0);

    // minute wrap 59 -> 0, no carry
    ore_curent = 5'd5; minute_curent = 6'd59; tick(1);
    semnal_setare = 1; tick(1);
    semnal_setare = 0; semnal_b2 = 1; tick(1);
    chk("wrap_min", int'(minute), 0);
    chk("wrap_min_ore", int'(ore), 5);
    semnal_b2 = 0; semnal_anulare = 1; tick(1);
    chk("abort_idle", int'(in_setare), 0);
    chk("abort_no_strobe", int'(load_timp), 0);
    quiet(); tick(1);

    // alarm slot 2 with auto-repeat
    sel_alarma = 2'd2; semnal_setare_a = 1; tick(1);
    chk("alarm_in", int'(in_setare), 1);
    chk("alarm_empty_ore", int'(ore), 0);
    semnal_setare_a = 0; semnal_b1 = 1; tick(1);
    chk("rep_edge", int'(ore), 1);
    tick(7);
    chk("rep_before_delay", int'(ore), 1);
    tick(1);
    chk("rep_first", int'(ore), 2);
    tick(2);
    chk("rep_before_rate", int'(ore), 2);
    tick(1);
    chk("rep_second", int'(ore), 3);
    semnal_b1 = 0; semnal_stop = 1; tick(1);
    chk("alarm_load", int'(load_alarma), 1);
    chk("alarm_load_timp0", int'(load_timp), 0);
    chk("alarm_idx", int'(idx_alarma), 2);
    semnal_stop = 0; tick(2);
    semnal_setare_a = 1; tick(1);
    chk("alarm_stored_ore", int'(ore), 3);
    chk("alarm_stored_min", int'(minute), 0);
    semnal_setare_a = 0; semnal_anulare = 1; tick(1);
    quiet(); tick(1);

    // simultaneous starts pick time; stop+abort aborts
    sel_alarma = 2'd1; semnal_setare = 1; semnal_setare_a = 1; tick(1);
    chk("both_start_time_ore", int'(ore), 5);
    quiet(); semnal_stop = 1; semnal_anulare = 1; tick(1);
    chk("stop_abort_idle", int'(in_setare), 0);
    chk("stop_abort_lt", int'(load_timp), 0);
    chk("stop_abort_la", int'(load_alarma), 0);
    quiet(); tick(1);
    semnal_setare = 1; semnal_setare_a = 1; tick(1);
    quiet(); semnal_stop = 1; tick(1);
    chk("both_start_lt", int'(load_timp), 1);
    chk("both_start_la", int'(load_alarma), 0);
    quiet(); tick(2);

    // b1, b2 and stop together from 10:20
    ore_curent = 5'd10; minute_curent = 6'd20; tick(1);
    semnal_setare = 1; tick(1);
    semnal_setare = 0; semnal_b1 = 1; semnal_b2 = 1; semnal_stop = 1; tick(1);
    chk("combo_lt", int'(load_timp), 1);
    chk("combo_ore", int'(ore), 11);
    chk("combo_min", int'(minute), 21);
    quiet(); tick(2);

    // reset mid-edit
    semnal_setare = 1; tick(1);
    semnal_setare = 0; semnal_b1 = 1; tick(1);
    reset = 0; #1;
    chk("midrst_in", int'(in_setare), 0);
    chk("midrst_ore", int'(ore), 0);
    chk("midrst_min", int'(minute), 0);
    chk("midrst_lt", int'(load_timp), 0);
    quiet(); tick(1);
    chk("midrst_hold", int'(ore), 0);
    reset = 1; tick(1);

    // randomized run
    hb1 = 0; hb2 = 0;
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 499) != 0);
      semnal_setare   = ($urandom_range(0, 29) == 0);
      semnal_setare_a = ($urandom_range(0, 29) == 0);
      sel_alarma      = 2'($urandom_range(0, 3));
      if (hb1) hb1 = ($urandom_range(0, 11) != 0); else hb1 = ($urandom_range(0, 7) == 0);
      if (hb2) hb2 = ($urandom_range(0, 11) != 0); else hb2 = ($urandom_range(0, 7) == 0);
      semnal_b1      = hb1;
      semnal_b2      = hb2;
      semnal_stop    = ($urandom_range(0, 14) == 0);
      semnal_anulare = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) begin
        ore_curent    = 5'($urandom_range(0, 23));
        minute_curent = 6'($urandom_range(0, 59));
      end
      tick(1);
    end
    reset = 1; quiet();
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
